// File: rtl/runway_pkg.sv
// Shared definitions for the runway lamp path: legal lamp patterns,
// lamp driver state enum and the pattern legality check.
package runway_pkg;

    // The four patterns the upstream direction FSM is allowed to produce
    localparam logic [2:0] PAT_ALPHA = 3'b101;
    localparam logic [2:0] PAT_BETA  = 3'b010;
    localparam logic [2:0] PAT_CHI   = 3'b001;
    localparam logic [2:0] PAT_DELTA = 3'b100;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } lamp_state_t;

    // Exact-match case: any X/Z bit falls through to the default and
    // reports the pattern as illegal.
    function automatic logic is_legal_pattern(input logic [2:0] pat);
        case (pat)
            PAT_ALPHA, PAT_BETA, PAT_CHI, PAT_DELTA: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/runway_lamp_driver_if.sv
// Pattern/lamp bundle between the direction FSM (master) and the
// runway lamp driver (slave).
interface runway_lamp_driver_if #(
    parameter int PWM_BITS = 4
);
    logic [2:0]          pat_in;
    logic                pat_valid;
    logic [PWM_BITS-1:0] bright;
    logic [2:0]          lamps;
    logic                busy;
    logic                illegal_seen;
    logic [7:0]          change_cnt;

    modport master (
        output pat_in, pat_valid, bright,
        input  lamps, busy, illegal_seen, change_cnt
    );

    modport slave (
        input  pat_in, pat_valid, bright,
        output lamps, busy, illegal_seen, change_cnt
    );
endinterface

// File: rtl/runway_lamp_driver_lamp_pwm.sv
// Lamp dimmer: free-running PWM counter compared against the brightness
// level. Full-scale brightness forces the lamps permanently on.
module lamp_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] bright,
    output logic                pwm_on
);
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                pwm_on_reg;

    // Counter wraps naturally; the compare result is registered so the
    // lamp gate only ever sees a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
            pwm_on_reg  <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            pwm_on_reg  <= (bright == '1) || (pwm_cnt_reg < bright);
        end
    end

    assign pwm_on = pwm_on_reg;
endmodule

// File: rtl/runway_lamp_driver.sv
// Runway lamp driver: shows the pattern from the direction FSM on the three
// runway lamps, holds each accepted pattern for at least DWELL cycles,
// flags illegal patterns and counts pattern changes (saturating).
// Optional PWM dimming is enabled by defining LAMP_PWM_EN.
module runway_lamp_driver #(
    parameter int DWELL    = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    runway_lamp_driver_if.slave  bus
);
    import runway_pkg::*;

    // The state literal DWELL is shadowed by the parameter of the same
    // name, so states are referenced through the package scope.
    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);

    lamp_state_t state_reg;
    logic [2:0]  cur_pat_reg;
    logic [7:0]  dwell_cnt_reg;
    logic        busy_reg;
    logic        illegal_reg;
    logic [7:0]  change_cnt_reg;
    logic        pwm_on;

    logic        pat_legal;
    logic        ready;
    logic        take;
    logic        flag_illegal;

    // Acceptance decision. The last dwell cycle (count at zero) is also the
    // first point a new pattern may be taken, so a pattern accepted at edge N
    // is shown for exactly DWELL cycles before the next one can replace it.
    always_comb begin
        pat_legal    = is_legal_pattern(bus.pat_in);
        ready        = (state_reg == runway_pkg::HOLD) ||
                       ((state_reg == runway_pkg::DWELL) && (dwell_cnt_reg == 8'd0));
        take         = bus.pat_valid && pat_legal &&
                       ((state_reg == runway_pkg::BLANK) ||
                        (ready && (bus.pat_in != cur_pat_reg)));
        flag_illegal = bus.pat_valid && !pat_legal &&
                       ((state_reg == runway_pkg::BLANK) || ready);
    end

    // Lamp state machine with registered busy/illegal/count outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= runway_pkg::BLANK;
            cur_pat_reg    <= 3'b000;
            dwell_cnt_reg  <= 8'd0;
            busy_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
            change_cnt_reg <= 8'd0;
        end else begin
            if (flag_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (take) begin
                cur_pat_reg   <= bus.pat_in;
                dwell_cnt_reg <= DWELL_RELOAD;
                state_reg     <= runway_pkg::DWELL;
                busy_reg      <= 1'b1;
                if (change_cnt_reg != 8'hFF) begin
                    change_cnt_reg <= change_cnt_reg + 8'd1;
                end
            end else begin
                case (state_reg)
                    runway_pkg::DWELL: begin
                        if (dwell_cnt_reg == 8'd0) begin
                            state_reg <= runway_pkg::HOLD;
                            busy_reg  <= 1'b0;
                        end else begin
                            dwell_cnt_reg <= dwell_cnt_reg - 8'd1;
                        end
                    end
                    default: begin
                        busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LAMP_PWM_EN
    lamp_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_lamp_pwm (
        .clk    (clk),
        .reset  (reset),
        .bright (bus.bright),
        .pwm_on (pwm_on)
    );
`else
    // Brightness has no effect without the dimmer
    logic unused_bright;
    assign unused_bright = ^bus.bright;
    assign pwm_on        = 1'b1;
`endif

    // cur_pat_reg is 000 whenever the driver is blank, so gating it with the
    // PWM enable covers every state.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lamp
            assign bus.lamps[gi] = cur_pat_reg[gi] & pwm_on;
        end
    endgenerate

    assign bus.busy         = busy_reg;
    assign bus.illegal_seen = illegal_reg;
    assign bus.change_cnt   = change_cnt_reg;
endmodule

// File: doc/runway_lamp_driver.md
# runway_lamp_driver

Downstream stage of the runway-direction FSM: takes the 3-bit lamp pattern it produces and drives the three physical runway lamps. Enforces a minimum dwell time per displayed pattern so lamps cannot flicker on noisy wind input, rejects illegal patterns, counts pattern changes and optionally dims the lamps with PWM. Output goes straight to the board LED/lamp pins.

## Interface
- DWELL, 8: minimum cycles a newly accepted pattern is held before another may be accepted; legal range 1..255
- PWM_BITS, 4: width of brightness control and PWM counter

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pat_in  in  3  pattern from upstream FSM
- pat_valid  in  1  pat_in is meaningful this cycle
- bright  in  PWM_BITS  lamp brightness level, used only with PWM feature
- lamps  out  3  lamp drive, bit 2 = left, bit 1 = centre, bit 0 = right
- busy  out  1  dwell in progress, new patterns ignored
- illegal_seen  out  1  sticky: an illegal pattern arrived with pat_valid
- change_cnt  out  8  count of accepted pattern changes, saturating at 255

## Operation
- Legal patterns: 3'b101, 3'b010, 3'b001, 3'b100. Anything else, including 000, 111, 011, 110 and X/Z bits, is illegal.
- States: BLANK (after reset, no pattern shown), DWELL (pattern shown, counting), HOLD (pattern shown, ready).
- BLANK: pat_valid & legal -> latch cur_pat, dwell_cnt = DWELL-1, change_cnt += 1, go DWELL.
- DWELL: inputs ignored (not latched, not checked for legality). dwell_cnt decrements each cycle; when dwell_cnt == 0, go HOLD on that edge.
- HOLD: pat_valid & legal & pat_in != cur_pat -> latch, reload dwell_cnt, change_cnt += 1, go DWELL. pat_in == cur_pat -> stay HOLD, no count.
- Illegal pattern with pat_valid in BLANK or HOLD: ignored, illegal_seen set to 1 and held until reset. pat_valid = 0: pat_in ignored in every state.
- change_cnt saturates at 255; no wrap.
- lamps = cur_pat gated by pwm_on (see Configuration); in BLANK, lamps = 3'b000.
- busy = 1 exactly in DWELL.

## Timing
- Reset values: lamps 000, busy 0, illegal_seen 0, change_cnt 0, state BLANK, cur_pat 000, PWM counter 0.
- Latency: pattern sampled at edge N appears on lamps after edge N (one cycle); busy rises after the same edge.
- Dwell: accepted at edge N -> busy high for exactly DWELL cycles; first new pattern accepted at edge N+DWELL. DWELL = 1 gives one busy cycle.
- Reset asserted mid-DWELL: next edge returns to BLANK, all outputs to reset values; reset wins over any simultaneous pat_valid.
- All outputs derive from flops; no combinational path from pat_in to lamps.

## Configuration
- LAMP_PWM_EN defined: free-running PWM_BITS counter pwm_cnt increments every cycle, wraps 2^PWM_BITS-1 -> 0. pwm_on = (pwm_cnt < bright) registered, except bright = all-ones forces pwm_on = 1. bright = 0 -> lamps dark while pattern state still tracked.
- LAMP_PWM_EN undefined: no PWM counter; pwm_on = 1 constantly; bright ignored; lamps = cur_pat whenever not in BLANK.

## Structure
- Shared package runway_pkg: pattern constants (ALPHA/BETA/CHI/DELTA patterns), lamp state enum {BLANK, DWELL, HOLD}, function is_legal_pattern(logic [2:0]) returning 0 for any X/Z.
- One sub-module: lamp_pwm (counter + compare, produces pwm_on), instantiated only under LAMP_PWM_EN.

## Test plan
- Reset, then pat_valid=1, pat_in=101 -> lamps 101 one cycle later, busy high 8 cycles, change_cnt 1.
- During busy, drive 010 with pat_valid -> ignored; lamps stay 101; after dwell, 010 accepted -> lamps 010, change_cnt 2.
- In HOLD, drive 010 again and 111 with pat_valid -> no change, change_cnt stays 2, illegal_seen 1 and stays 1 thereafter.
- Alternate 001/100 each dwell period 300 times -> change_cnt saturates at 255.
- Reset asserted at 3rd busy cycle -> next cycle lamps 000, busy 0, illegal_seen 0, change_cnt 0.
- With LAMP_PWM_EN, bright=4, pattern 100 -> lamps[2] high 4 of every 16 cycles; bright=15 -> always high; bright=0 -> always low.
